// File: rtl/ps2_cmd_pkg.sv
// Shared types and constants for the PS/2 command assembler.
// Holds the decoder state enum and the set-2 scancodes the decoder reacts to.
package ps2_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } dec_state_e;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;
    localparam logic [7:0] ENTER = 8'h5A;
    localparam logic [7:0] BKSP  = 8'h66;
    localparam logic [7:0] ESC   = 8'h76;
    localparam logic [7:0] SPACE = 8'h29;

    localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/ps2_ascii_map.sv
// Combinational set-2 make-code to ASCII lookup for letters, digits and space.
// Any code outside that set reports printable=0 and ascii=NUL.
module ps2_ascii_map
    import ps2_cmd_pkg::*;
(
    input  logic [7:0] code,
    output logic [7:0] ascii,
    output logic       printable
);

    always_comb begin
        ascii = ASCII_NUL;
        case (code)
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;
            8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;
            8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;
            8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;
            8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;
            8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;
            8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;
            8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            SPACE: ascii = 8'h20;
            default: ascii = ASCII_NUL;
        endcase
        printable = (ascii != ASCII_NUL);
    end

endmodule

// File: rtl/ps2_cmd_assembler.sv
// Assembles PS/2 set-2 make codes into a left-justified ASCII command committed on Enter.
// Define PS2_CMD_EDIT_EN to enable Backspace (0x66) and Escape (0x76) editing.
module ps2_cmd_assembler
    import ps2_cmd_pkg::*;
#(
    parameter int MAX_CHARS = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     key_data,
    input  logic                           key_valid,
    output logic [8*MAX_CHARS-1:0]         cmd_data,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [$clog2(MAX_CHARS+1)-1:0] char_count,
    output logic [7:0]                     last_ascii,
    output logic                           overflow
);

    localparam int W  = 8 * MAX_CHARS;
    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CHARS);

    dec_state_e    state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  cmd_data_q, cmd_data_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    last_ascii_q, last_ascii_d;
    logic          overflow_q, overflow_d;

    logic [7:0] map_ascii;
    logic       map_printable;
    logic       is_make;

    ps2_ascii_map u_map (
        .code      (key_data),
        .ascii     (map_ascii),
        .printable (map_printable)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        count_d      = count_q;
        cmd_data_d   = cmd_data_q;
        cmd_valid_d  = cmd_valid_q;
        last_ascii_d = last_ascii_q;
        overflow_d   = overflow_q;
        is_make      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    if (key_data == BREAK) begin
                        state_d = S_BREAK;
                    end else if (key_data == EXT) begin
                        state_d = S_EXT;
                    end else begin
                        is_make = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (key_valid) state_d = S_IDLE;
            end
            S_EXT: begin
                if (key_valid) state_d = (key_data == BREAK) ? S_EXT_BREAK : S_IDLE;
            end
            S_EXT_BREAK: begin
                if (key_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;

        if (is_make) begin
            if (map_printable) begin
                if (count_q < MAX_CNT) begin
                    buf_d        = {buf_q[W-9:0], map_ascii};
                    count_d      = count_q + CW'(1);
                    last_ascii_d = map_ascii;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (key_data == ENTER) begin
                if (count_q != '0) begin
                    if (!cmd_valid_q || cmd_ready) begin
                        // Characters sit in the low bytes; shift so the first one lands in the MSB.
                        cmd_data_d  = buf_q << (8 * (MAX_CHARS - int'(count_q)));
                        cmd_valid_d = 1'b1;
                        buf_d       = '0;
                        count_d     = '0;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
`ifdef PS2_CMD_EDIT_EN
            end else if (key_data == BKSP) begin
                if (count_q != '0) begin
                    buf_d   = buf_q >> 8;
                    count_d = count_q - CW'(1);
                end
            end else if (key_data == ESC) begin
                buf_d   = '0;
                count_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            count_q      <= '0;
            cmd_data_q   <= '0;
            cmd_valid_q  <= 1'b0;
            last_ascii_q <= ASCII_NUL;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            cmd_data_q   <= cmd_data_d;
            cmd_valid_q  <= cmd_valid_d;
            last_ascii_q <= last_ascii_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cmd_data   = cmd_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign char_count = count_q;
    assign last_ascii = last_ascii_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_cmd_assembler.sv
// Directed, self-checking bench for ps2_cmd_assembler (MAX_CHARS=4).
// Committed commands are predicted into a scoreboard queue and popped as the DUT presents them.
module tb_ps2_cmd_assembler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  key_data = 8'h00;
    logic        key_valid = 1'b0;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  char_count;
    logic [7:0]  last_ascii;
    logic        overflow;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cmd;

    ps2_cmd_assembler #(.MAX_CHARS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .char_count (char_count),
        .last_ascii (last_ascii),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        key_data  = b;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset     = 1'b1;
        key_data  = 8'h1C;
        key_valid = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        reset     = 1'b0;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_cmd_valid got=%b want=0", cmd_valid); end
        total++; if (cmd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_cmd_data got=%h want=00000000", cmd_data); end
        total++; if (char_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_char_count got=%0d want=0", char_count); end
        total++; if (last_ascii !== 8'h00) begin bad++; $display("[TB] FAIL reset_last_ascii got=%h want=00", last_ascii); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_typing();
        logic [7:0] seq [4];
        seq = '{8'h2B, 8'h23, 8'h29, 8'h2E};
        cmd_ready = 1'b1;
        @(negedge clock);
        key_data = 8'h1C;
        @(negedge clock);
        total++; if (char_count !== 3'd0) begin bad++; $display("[TB] FAIL no_valid_ignored got=%0d want=0", char_count); end
        for (int i = 0; i < 4; i++) send_byte(seq[i]);
        total++; if (char_count !== 3'd4) begin bad++; $display("[TB] FAIL typing_count got=%0d want=4", char_count); end
        total++; if (last_ascii !== 8'h35) begin bad++; $display("[TB] FAIL typing_last_ascii got=%h want=35", last_ascii); end
        exp_q.push_back(32'h46442035);
        send_byte(8'h5A);
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("[TB] FAIL typing_valid got=%b want=1", cmd_valid); end
        exp_cmd = exp_q.pop_front();
        total++; if (cmd_data !== exp_cmd) begin bad++; $display("[TB] FAIL typing_cmd got=%h want=%h", cmd_data, exp_cmd); end
        total++; if (char_count !== 3'd0) begin bad++; $display("[TB] FAIL typing_clear got=%0d want=0", char_count); end
        @(negedge clock);
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL typing_valid_drop got=%b want=0", cmd_valid); end
    endtask

    task automatic test_break();
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if (char_count !== 3'd1) begin bad++; $display("[TB] FAIL break_count got=%0d want=1", char_count); end
        exp_q.push_back(32'h41000000);
        send_byte(8'h5A);
        exp_cmd = exp_q.pop_front();
        total++; if (cmd_valid !== 1'b1 || cmd_data !== exp_cmd) begin bad++; $display("[TB] FAIL break_cmd got=%b/%h want=1/%h", cmd_valid, cmd_data, exp_cmd); end
        send_byte(8'h5A);
        total++; if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL empty_enter got=%b/%b want=0/0", cmd_valid, overflow); end
    endtask

    task automatic test_ext_overflow();
        logic [7:0] ext [5];
        logic [7:0] keys [5];
        ext  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(ext[i]);
        total++; if (char_count !== 3'd0 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL ext_ignored got=%0d/%b want=0/0", char_count, overflow); end
        for (int i = 0; i < 5; i++) send_byte(keys[i]);
        total++; if (char_count !== 3'd4 || overflow !== 1'b1) begin bad++; $display("[TB] FAIL overflow got=%0d/%b want=4/1", char_count, overflow); end
        total++; if (last_ascii !== 8'h44) begin bad++; $display("[TB] FAIL overflow_last got=%h want=44", last_ascii); end
        exp_q.push_back(32'h41424344);
        send_byte(8'h5A);
        exp_cmd = exp_q.pop_front();
        total++; if (cmd_valid !== 1'b1 || cmd_data !== exp_cmd) begin bad++; $display("[TB] FAIL overflow_cmd got=%b/%h want=1/%h", cmd_valid, cmd_data, exp_cmd); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd_ready = 1'b0;
        send_byte(8'h1C);
        exp_q.push_back(32'h41000000);
        send_byte(8'h5A);
        total++; if (cmd_valid !== 1'b1 || cmd_data !== exp_q[0]) begin bad++; $display("[TB] FAIL bp_first got=%b/%h want=1/%h", cmd_valid, cmd_data, exp_q[0]); end
        send_byte(8'h32);
        send_byte(8'h5A);
        total++; if (overflow !== 1'b1 || char_count !== 3'd1) begin bad++; $display("[TB] FAIL bp_drop got=%b/%0d want=1/1", overflow, char_count); end
        total++; if (cmd_data !== exp_q[0]) begin bad++; $display("[TB] FAIL bp_stable got=%h want=%h", cmd_data, exp_q[0]); end
        @(negedge clock);
        cmd_ready = 1'b1;
        key_data  = 8'h5A;
        key_valid = 1'b1;
        exp_q.push_back(32'h42000000);
        @(negedge clock);
        void'(exp_q.pop_front());
        key_valid = 1'b0;
        cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd_data !== exp_q[0]) begin bad++; $display("[TB] FAIL bp_reload got=%b/%h want=1/%h", cmd_valid, cmd_data, exp_q[0]); end
        total++; if (char_count !== 3'd0) begin bad++; $display("[TB] FAIL bp_reload_count got=%0d want=0", char_count); end
        @(negedge clock);
        cmd_ready = 1'b1;
        @(negedge clock);
        void'(exp_q.pop_front());
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_accept got=%b want=0", cmd_valid); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_edit();
        do_reset();
        cmd_ready = 1'b1;
`ifdef PS2_CMD_EDIT_EN
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'h66);
        send_byte(8'h21);
        total++; if (char_count !== 3'd2) begin bad++; $display("[TB] FAIL edit_count got=%0d want=2", char_count); end
        exp_q.push_back(32'h41430000);
        send_byte(8'h5A);
        exp_cmd = exp_q.pop_front();
        total++; if (cmd_valid !== 1'b1 || cmd_data !== exp_cmd) begin bad++; $display("[TB] FAIL edit_cmd got=%b/%h want=1/%h", cmd_valid, cmd_data, exp_cmd); end
        send_byte(8'h1C);
        send_byte(8'h76);
        total++; if (char_count !== 3'd0) begin bad++; $display("[TB] FAIL esc_clear got=%0d want=0", char_count); end
`else
        send_byte(8'h1C);
        send_byte(8'h66);
        total++; if (char_count !== 3'd1) begin bad++; $display("[TB] FAIL bksp_unmapped got=%0d want=1", char_count); end
        send_byte(8'h76);
        total++; if (char_count !== 3'd1 || last_ascii !== 8'h41) begin bad++; $display("[TB] FAIL esc_unmapped got=%0d/%h want=1/41", char_count, last_ascii); end
`endif
    endtask

    task automatic test_reset_break();
        do_reset();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        total++; if (char_count !== 3'd1) begin bad++; $display("[TB] FAIL rst_break_count got=%0d want=1", char_count); end
        total++; if (last_ascii !== 8'h41) begin bad++; $display("[TB] FAIL rst_break_ascii got=%h want=41", last_ascii); end
    endtask

    initial begin
        test_reset();
        test_typing();
        test_break();
        test_ext_overflow();
        test_back_to_back();
        test_edit();
        test_reset_break();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_assembler.md
PS2_CMD_ASSEMBLER -- requirements
Module: ps2_cmd_assembler

Interface
REQ-001 The block SHALL have parameter MAX_CHARS, default 4, giving the maximum characters per command; the output word is 8*MAX_CHARS bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the following data and handshake ports:
- key_data  input  8  raw PS/2 set-2 byte from the keyboard interface.
- key_valid  input  1  one-cycle strobe; key_data is valid this cycle.
- cmd_data  output  8*MAX_CHARS  committed command, first-typed char in the most significant byte.
- cmd_valid  output  1  command available; held until accepted.
- cmd_ready  input  1  consumer accepts cmd_data when high with cmd_valid.
- char_count  output  $clog2(MAX_CHARS+1)  characters currently in the edit buffer.
- last_ascii  output  8  ASCII of the last accepted printable key, for LCD/segment display.
- overflow  output  1  sticky; a key or Enter was dropped.

Function
REQ-004 The decoder SHALL be an FSM with states S_IDLE, S_BREAK, S_EXT and S_EXT_BREAK, advancing only on key_valid.
REQ-005 Decoder transitions SHALL be:
- S_IDLE: 0xF0 goes to S_BREAK; 0xE0 goes to S_EXT; any other byte is a make code and the FSM stays in S_IDLE.
- S_BREAK: any byte goes to S_IDLE and is discarded.
- S_EXT: 0xF0 goes to S_EXT_BREAK; any other byte goes to S_IDLE and is discarded (extended keys are ignored).
- S_EXT_BREAK: any byte goes to S_IDLE.
REQ-006 The ASCII map SHALL cover set-2 make codes as follows:
- A-Z map to 0x41-0x5A.
- 0-9 map to 0x30-0x39, with 0x26 mapping to '3' and 0x2B mapping to 'F'.
- 0x29 maps to 0x20 (space).
- All other codes are unmapped.
REQ-007 A printable make with char_count<MAX_CHARS SHALL update state as follows:
- buffer <= {buffer[8*MAX_CHARS-9:0], ascii}.
- char_count increments.
- last_ascii <= ascii.
REQ-008 A printable make with char_count==MAX_CHARS SHALL be dropped and SHALL set overflow; the buffer is unchanged.
REQ-009 Enter (0x5A) with char_count>0 SHALL commit, provided cmd_valid is low or cmd_ready is high in the same cycle. On commit:
- cmd_data <= buffer, left-justified so unused low bytes are 0x00.
- cmd_valid <= 1.
- Buffer and char_count clear.
REQ-010 Enter with char_count==0 SHALL be ignored without setting overflow.
REQ-011 Enter while cmd_valid is high and cmd_ready is low SHALL be dropped and SHALL set overflow; the buffer is retained.
REQ-012 While cmd_valid is high, cmd_data SHALL stay stable; cmd_valid SHALL clear the cycle after cmd_valid&&cmd_ready unless REQ-009 reloads it in the same cycle.
REQ-013 Editing the buffer while a command is pending SHALL be permitted.
REQ-014 Unmapped make codes SHALL have no effect.
REQ-015 Latency SHALL be one cycle: key_valid at edge N is reflected in all outputs after edge N+1.
REQ-016 Bytes arriving without key_valid SHALL be ignored.

Reset
REQ-017 Reset SHALL synchronously set the following, overriding any simultaneous key_valid or handshake:
- FSM goes to S_IDLE.
- cmd_data, buffer, char_count and last_ascii go to 0.
- cmd_valid goes to 0.
- overflow goes to 0.
REQ-018 A reset between 0xF0 and the following byte SHALL cause that following byte to be decoded as a make code.

Configuration
REQ-019 With PS2_CMD_EDIT_EN defined, the block SHALL support editing keys:
- Backspace (0x66) with char_count>0 sets buffer <= buffer>>8 and decrements char_count.
- Backspace with char_count==0 is a no-op.
- Escape (0x76) clears the buffer and char_count.
REQ-020 Without PS2_CMD_EDIT_EN, codes 0x66 and 0x76 SHALL be treated as unmapped (REQ-014).

Structure
REQ-021 Package ps2_cmd_pkg SHALL hold the following:
- Decoder state enum.
- Scancode constants: BREAK=0xF0, EXT=0xE0, ENTER=0x5A, BKSP=0x66, ESC=0x76, SPACE=0x29.
- ASCII NUL constant.
REQ-022 A combinational sub-module ps2_ascii_map SHALL provide the following:
- Input: an 8-bit code.
- Outputs: ascii[7:0] and printable.
- Instantiated once.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Typing "FD 5": bytes 2B,23,29,2E, Enter 5A, cmd_ready=1 -> cmd_data=0x46442035, cmd_valid high one cycle, char_count=0.
- Break handling: 1C,F0,1C,5A -> cmd_data=0x41000000; the break byte 1C is not appended.
- Extended/overflow: E0,75,E0,F0,75 leaves the buffer unchanged; 5 printable makes -> char_count=4, overflow=1, first 4 chars kept.
- Back-pressure: commit "A" with cmd_ready=0, type "B", Enter -> overflow=1, cmd_data stays 0x41000000, char_count=1; then cmd_ready=1 and Enter in the same cycle -> cmd_data=0x42000000, cmd_valid stays high.
- With PS2_CMD_EDIT_EN: 1C,32,66,21,5A -> 0x41430000; 76 after 1C leaves char_count=0. Without the macro, 66 leaves char_count unchanged.
- Reset after a lone F0, then 1C -> char_count=1 and last_ascii=0x41.
